// File: rtl/vga_pkg.sv
// Shared constants for the VGA drawing path: screen geometry, pixel field widths
// and the fixed requester indices used by the write arbiter.
package vga_pkg;

    localparam int H_RES      = 320;
    localparam int V_RES      = 240;
    localparam int COLOR_W    = 3;
    localparam int X_W        = 9;
    localparam int Y_W        = 8;

    localparam int REQ_BG     = 0;
    localparam int REQ_CURSOR = 1;
    localparam int REQ_TEXT   = 2;

    typedef logic [1:0] req_idx_t;

    // Next requester index, wrapping n-1 back to 0.
    function automatic req_idx_t wrap_inc(input req_idx_t idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Pixel-write bus between the drawing requesters and the arbiter, plus the
// arbiter's registered write port towards the VGA adapter.
interface vga_write_arbiter_if #(
    parameter int N_REQ   = 3,
    parameter int COLOR_W = 3
);

    logic [N_REQ-1:0]         iReq;
    logic [N_REQ-1:0]         iLock;
    logic [9*N_REQ-1:0]       iX;
    logic [8*N_REQ-1:0]       iY;
    logic [COLOR_W*N_REQ-1:0] iColor;
    logic                     iHold;
    logic [N_REQ-1:0]         oGnt;
    logic [8:0]               oX;
    logic [7:0]               oY;
    logic [COLOR_W-1:0]       oColor;
    logic                     oWriteEn;
    logic [1:0]               oOwner;
    logic                     oLocked;
    logic [15:0]              oDropCount;

    modport master (
        output iReq, iLock, iX, iY, iColor, iHold,
        input  oGnt, oX, oY, oColor, oWriteEn, oOwner, oLocked, oDropCount
    );

    modport slave (
        input  iReq, iLock, iX, iY, iColor, iHold,
        output oGnt, oX, oY, oColor, oWriteEn, oOwner, oLocked, oDropCount
    );

endinterface

// File: rtl/vga_rr_pick.sv
// Rotating-priority encoder: first requesting index at or after ptr wins,
// wrapping from N_REQ-1 back to 0.
module vga_rr_pick
    import vga_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         ptr,
    output logic [N_REQ-1:0] gnt,
    output req_idx_t         idx,
    output logic             valid
);

    int j;

    // Scan from the farthest candidate down so the nearest one to ptr wins last.
    always_comb begin
        gnt   = '0;
        idx   = ptr;
        valid = 1'b0;
        j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (req[j]) begin
                idx   = req_idx_t'(j);
                valid = 1'b1;
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Shares the VGA adapter's single pixel-write port among N_REQ drawing engines
// with round-robin arbitration, capped burst locking and off-screen clipping.
module vga_write_arbiter
    import vga_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int H_RES     = vga_pkg::H_RES,
    parameter int V_RES     = vga_pkg::V_RES,
    parameter int MAX_BURST = 16,
    parameter int COLOR_W   = vga_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               iReset,
    vga_write_arbiter_if.slave bus
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);
    localparam logic [X_W-1:0] X_LIM     = X_W'(H_RES);
    localparam logic [Y_W-1:0] Y_LIM     = Y_W'(V_RES);

    req_idx_t           ptr_q, ptr_d;
    req_idx_t           owner_q, owner_d;
    logic               locked_q, locked_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               we_q, we_d;
    logic [15:0]        drop_q, drop_d;

    req_idx_t           owner_next;
    req_idx_t           rr_ptr;
    logic [N_REQ-1:0]   rr_gnt;
    req_idx_t           rr_idx;
    logic               rr_valid;

    logic [N_REQ-1:0]   gnt;
    logic               granted;
    req_idx_t           win;
    logic [BW-1:0]      burst_inc;
    logic [X_W-1:0]     win_x;
    logic [Y_W-1:0]     win_y;
    logic [COLOR_W-1:0] win_color;
    logic               clipped;

    // A lock that is not continued this cycle hands priority to the next index,
    // so the others are arbitrated in the very cycle the owner drops out.
    assign owner_next = wrap_inc(owner_q, N_REQ);
    assign rr_ptr     = locked_q ? owner_next : ptr_q;
    assign burst_inc  = burst_q + 1'b1;

    vga_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (bus.iReq),
        .ptr   (rr_ptr),
        .gnt   (rr_gnt),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    always_comb begin
        gnt      = '0;
        granted  = 1'b0;
        win      = owner_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        locked_d = locked_q;
        burst_d  = burst_q;
        if (!iReset && !bus.iHold) begin
            if (locked_q && bus.iReq[owner_q]) begin
                granted      = 1'b1;
                gnt[owner_q] = 1'b1;
                burst_d      = burst_inc;
                if (!bus.iLock[owner_q] || burst_inc == BURST_MAX) begin
                    locked_d = 1'b0;
                    burst_d  = '0;
                    ptr_d    = owner_next;
                end
            end else begin
                locked_d = 1'b0;
                burst_d  = '0;
                ptr_d    = rr_ptr;
                if (rr_valid) begin
                    granted = 1'b1;
                    gnt     = rr_gnt;
                    win     = rr_idx;
                    ptr_d   = wrap_inc(rr_idx, N_REQ);
                    if (bus.iLock[rr_idx] && MAX_BURST > 1) begin
                        locked_d = 1'b1;
                        owner_d  = rr_idx;
                        burst_d  = BW'(1);
                    end
                end
            end
        end
    end

    assign win_x     = bus.iX[X_W*int'(win) +: X_W];
    assign win_y     = bus.iY[Y_W*int'(win) +: Y_W];
    assign win_color = bus.iColor[COLOR_W*int'(win) +: COLOR_W];
    assign clipped   = (win_x >= X_LIM) || (win_y >= Y_LIM);

    // Clipped pixels are still acknowledged but never reach the adapter.
    always_comb begin
        we_d    = granted && !clipped;
        x_d     = we_d ? win_x : x_q;
        y_d     = we_d ? win_y : y_q;
        color_d = we_d ? win_color : color_q;
        drop_d  = drop_q;
        if (granted && clipped && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            ptr_q    <= req_idx_t'(REQ_BG);
            owner_q  <= '0;
            locked_q <= 1'b0;
            burst_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
            we_q     <= 1'b0;
            drop_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            burst_q  <= burst_d;
            x_q      <= x_d;
            y_q      <= y_d;
            color_q  <= color_d;
            we_q     <= we_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.oGnt       = gnt;
    assign bus.oX         = x_q;
    assign bus.oY         = y_q;
    assign bus.oColor     = color_q;
    assign bus.oWriteEn   = we_q;
    assign bus.oOwner     = owner_q;
    assign bus.oLocked    = locked_q;
    assign bus.oDropCount = drop_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Self-checking bench for vga_write_arbiter: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_vga_write_arbiter;
    import vga_pkg::*;

    localparam int N    = 3;
    localparam int MAXB = 16;

    logic clk = 1'b0;
    logic iReset;
    always #5 clk = ~clk;

    vga_write_arbiter_if #(.N_REQ(N), .COLOR_W(COLOR_W)) bus ();

    vga_write_arbiter #(
        .N_REQ     (N),
        .H_RES     (H_RES),
        .V_RES     (V_RES),
        .MAX_BURST (MAXB),
        .COLOR_W   (COLOR_W)
    ) dut (
        .clk    (clk),
        .iReset (iReset),
        .bus    (bus)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic         hold;
        logic [N-1:0] gnt;
    } vec_t;

    int checks = 0;
    int fails  = 0;

    logic [N-1:0] req, lock, act_gnt;
    logic         hold, rst;
    int           px[N], py[N], pc[N];
    int           last_gnt;
    int           gnt_log[$];

    int m_ptr, m_owner, m_burst, m_drop, m_x, m_y, m_c;
    bit m_locked, m_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_burst = 0; m_drop = 0;
        m_x = 0; m_y = 0; m_c = 0; m_locked = 0; m_we = 0;
    endtask

    // One clock: drive inputs, predict the grant, compare at negedge, advance model.
    task automatic step();
        int w, start, idx;
        bit cont;
        logic [N-1:0] eg;
        iReset     = rst;
        bus.iReq   = req;
        bus.iLock  = lock;
        bus.iHold  = hold;
        for (int i = 0; i < N; i++) begin
            bus.iX[9*i +: 9]                 = 9'(px[i]);
            bus.iY[8*i +: 8]                 = 8'(py[i]);
            bus.iColor[COLOR_W*i +: COLOR_W] = COLOR_W'(pc[i]);
        end
        w = -1; cont = 0; start = m_ptr;
        if (!rst && !hold) begin
            if (m_locked && req[m_owner]) begin
                w = m_owner; cont = 1;
            end else begin
                if (m_locked) start = (m_owner + 1) % N;
                for (int k = 0; k < N; k++) begin
                    idx = (start + k) % N;
                    if (w < 0 && req[idx]) w = idx;
                end
            end
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        @(negedge clk);
        act_gnt = bus.oGnt;
        check("gnt", 32'(bus.oGnt), 32'(eg));
        check("writeEn", 32'(bus.oWriteEn), 32'(m_we));
        if (m_we) begin
            check("x", 32'(bus.oX), 32'(m_x));
            check("y", 32'(bus.oY), 32'(m_y));
            check("color", 32'(bus.oColor), 32'(m_c));
        end
        check("locked", 32'(bus.oLocked), 32'(m_locked));
        if (m_locked) check("owner", 32'(bus.oOwner), 32'(m_owner));
        check("dropCount", 32'(bus.oDropCount), 32'(m_drop));
        last_gnt = w;
        if (w >= 0) gnt_log.push_back(w);
        if (rst) begin
            model_reset();
        end else if (hold) begin
            m_we = 0;
        end else begin
            if (m_locked && !cont) begin
                m_locked = 0; m_burst = 0;
            end
            if (w < 0) begin
                m_ptr = start; m_we = 0;
            end else begin
                if (cont) begin
                    m_burst++;
                    if (!lock[w] || m_burst == MAXB) begin
                        m_locked = 0; m_burst = 0; m_ptr = (w + 1) % N;
                    end
                end else begin
                    m_ptr = (w + 1) % N;
                    if (lock[w]) begin
                        m_locked = 1; m_owner = w; m_burst = 1;
                    end
                end
                if (px[w] >= H_RES || py[w] >= V_RES) begin
                    m_we = 0;
                    if (m_drop < 65535) m_drop++;
                end else begin
                    m_we = 1; m_x = px[w]; m_y = py[w]; m_c = pc[w];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst = 1; req = '0; lock = '0; hold = 0;
        step();
        rst = 0;
        gnt_log.delete();
    endtask

    task automatic setDefaultPixels();
        for (int i = 0; i < N; i++) begin
            px[i] = 10 * i + 1; py[i] = 20 + i; pc[i] = i + 1;
        end
    endtask

    vec_t tbl[11];
    int   cnt;

    initial begin
        tbl[0]  = '{3'b111, 3'b000, 1'b0, 3'b001};
        tbl[1]  = '{3'b111, 3'b000, 1'b0, 3'b010};
        tbl[2]  = '{3'b111, 3'b000, 1'b0, 3'b100};
        tbl[3]  = '{3'b111, 3'b000, 1'b0, 3'b001};
        tbl[4]  = '{3'b111, 3'b000, 1'b0, 3'b010};
        tbl[5]  = '{3'b111, 3'b000, 1'b0, 3'b100};
        tbl[6]  = '{3'b111, 3'b000, 1'b1, 3'b000};
        tbl[7]  = '{3'b000, 3'b000, 1'b0, 3'b000};
        tbl[8]  = '{3'b010, 3'b000, 1'b0, 3'b010};
        tbl[9]  = '{3'b101, 3'b000, 1'b0, 3'b100};
        tbl[10] = '{3'b101, 3'b000, 1'b0, 3'b001};

        iReset = 1'b1;
        bus.iReq = '0; bus.iLock = '0; bus.iHold = 1'b0;
        bus.iX = '0; bus.iY = '0; bus.iColor = '0;
        setDefaultPixels();
        model_reset();
        @(posedge clk);
        #1;

        // Round-robin vector table
        applyReset();
        foreach (tbl[i]) begin
            req = tbl[i].req; lock = tbl[i].lock; hold = tbl[i].hold;
            step();
            check("tbl_gnt", 32'(act_gnt), 32'(tbl[i].gnt));
        end

        // Burst cap: req0 locked against a continuous req1
        applyReset();
        req = 3'b011; lock = 3'b001;
        for (int i = 0; i < 40; i++) step();
        for (int i = 0; i < 33; i++) check("burst_seq", 32'(gnt_log[i]), (i == 16) ? 32'd1 : 32'd0);

        // Clipping on both axes, then a corner pixel that is on screen
        applyReset();
        req = 3'b100; lock = 3'b000;
        px[2] = 320; py[2] = 10;  step();
        px[2] = 5;   py[2] = 240; step();
        px[2] = 319; py[2] = 239; step();
        check("clip_we", 32'(bus.oWriteEn), 32'd1);
        check("clip_x", 32'(bus.oX), 32'd319);
        check("clip_y", 32'(bus.oY), 32'd239);
        check("clip_drops", 32'(bus.oDropCount), 32'd2);
        setDefaultPixels();

        // Hold in the middle of a req1 burst
        applyReset();
        req = 3'b011; lock = 3'b010;
        for (int i = 0; i < 4; i++) step();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_gnt", 32'(act_gnt), 32'd0);
        end
        hold = 0;
        gnt_log.delete();
        for (int i = 0; i < 14; i++) step();
        for (int i = 0; i < 14; i++) check("hold_burst", 32'(gnt_log[i]), (i < 13) ? 32'd1 : 32'd0);

        // Reset in cycle 5 of a req2 burst, after one clipped pixel
        applyReset();
        req = 3'b100; lock = 3'b100;
        px[2] = 400; step();
        px[2] = 30;
        for (int i = 0; i < 3; i++) step();
        rst = 1; step();
        check("rst_gnt", 32'(act_gnt), 32'd0);
        rst = 0; req = 3'b110; lock = 3'b000;
        step();
        check("rst_first_gnt", 32'(act_gnt), 32'b010);
        setDefaultPixels();

        // Lone unlocked requester streams with no bubbles
        applyReset();
        req = 3'b010; lock = 3'b000;
        for (int i = 0; i < 10; i++) begin
            py[1] = 50 + i;
            step();
            check("stream_gnt", 32'(act_gnt), 32'b010);
            check("stream_we", 32'(bus.oWriteEn), 32'd1);
        end

        // Randomized traffic against the model
        applyReset();
        cnt = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (last_gnt == i || !req[i]) begin
                    px[i] = $urandom_range(0, 340);
                    py[i] = $urandom_range(0, 250);
                    pc[i] = $urandom_range(0, 7);
                end
            end
            req  = N'($urandom_range(0, 7));
            lock = N'($urandom_range(0, 7) | (($urandom_range(0, 3) != 0) ? 7 : 0));
            hold = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            step();
            if (last_gnt >= 0) cnt++;
        end
        rst = 0;
        check("random_activity", 32'(cnt > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Shares the VGA adapter's single pixel-write port (x, y, color, writeEn) among N_REQ drawing requesters: 0 = background ROM blitter, 1 = cursor overlay, 2 = score/text renderer.
- Round-robin arbitration with optional burst lock, bounded by MAX_BURST.
- Clips off-screen pixels and counts them.
- Sits between the drawing FSMs and the VGA adapter, one instance per display.

Parameters:
- N_REQ, 3, number of requesters (2..4)
- H_RES, 320, horizontal resolution; writes with x >= H_RES are clipped
- V_RES, 240, vertical resolution; writes with y >= V_RES are clipped
- MAX_BURST, 16, maximum consecutive locked grants to one requester
- COLOR_W, 3, color width

Ports:
- clk  in  1  clock
- iReset  in  1  synchronous, active-high reset
- iReq  in  N_REQ  per-requester pixel valid
- iLock  in  N_REQ  requester asks to keep ownership after this beat
- iX  in  9*N_REQ  packed x; requester i uses bits [9i+8:9i]
- iY  in  8*N_REQ  packed y; requester i uses bits [8i+7:8i]
- iColor  in  COLOR_W*N_REQ  packed color
- iHold  in  1  adapter not accepting; suspends arbitration
- oGnt  out  N_REQ  one-hot, combinational; pixel accepted this cycle
- oX  out  9  registered x to adapter
- oY  out  8  registered y to adapter
- oColor  out  COLOR_W  registered color to adapter
- oWriteEn  out  1  registered write strobe
- oOwner  out  2  current lock owner index, valid when oLocked = 1
- oLocked  out  1  a burst lock is active
- oDropCount  out  16  number of clipped pixels, saturating

Behaviour:
- Reset: all registered outputs are 0. Round-robin pointer = 0, no lock, burst count = 0, oDropCount = 0. Reset overrides all other inputs in the same cycle.
- Handshake:
  - A beat transfers when iReq[i] & oGnt[i].
  - A requester must hold x/y/color stable while iReq is high and oGnt is low.
  - After seeing oGnt, the requester may present its next pixel in the following cycle.
- oGnt is asserted only when iHold = 0 and at least one iReq is high; at most one bit is set.
- Latency: a pixel granted in cycle t appears on oX/oY/oColor with oWriteEn = 1 in cycle t+1. With no grant, oWriteEn = 0 in t+1 and oX/oY/oColor hold their previous values.
- Arbitration when no lock is active:
  - The first requesting index at or after the pointer, wrapping N_REQ-1 -> 0, wins.
  - After the grant, pointer = winner+1 mod N_REQ.
- Lock:
  - If the winner has iLock high on its granted beat, the lock is set: owner = winner, burst count = 1.
  - While locked, the owner is granted whenever it requests, and burst count increments on each grant.
  - The lock is released when any of the following occurs:
    - owner's iReq = 0 in a cycle with iHold = 0
    - owner's iLock = 0 on a granted beat
    - burst count reaches MAX_BURST
  - In the release cycle the pointer = owner+1, so others get the next decision.
  - Release on a dropped iReq costs no bubble: the same cycle arbitrates round-robin among the others.
- Burst cap: the grant that brings burst count to MAX_BURST still transfers. The next decision ignores that requester's iLock from the previous burst and uses round-robin.
- iHold = 1: no grants, oWriteEn = 0 the next cycle, lock/owner/pointer/burst count unchanged.
- Clipping: a granted pixel with x >= H_RES or y >= V_RES is still acknowledged via oGnt. The next cycle has oWriteEn = 0, and oDropCount increments, saturating at 65535.
- Reset during a burst clears the lock; the requester sees no oGnt in the reset cycle.

Decomposition:
- Shared package vga_pkg holds:
  - H_RES = 320, V_RES = 240, COLOR_W = 3
  - requester index constants REQ_BG = 0, REQ_CURSOR = 1, REQ_TEXT = 2
  - X_W = 9, Y_W = 8
- Sub-module vga_rr_pick: combinational rotating-priority encoder. Inputs are the request vector and pointer; outputs are a one-hot grant and the winner index. The lock override stays in vga_write_arbiter.

Test Plan:
- Reset, then iReq = 3'b111 with no locks held for 6 cycles -> oGnt sequence 001, 010, 100, 001, 010, 100. oWriteEn = 1 one cycle after each grant, with oX/oY/oColor equal to the granted requester's inputs.
- Requester 0 holds iReq and iLock for 40 cycles, requester 1 requests continuously, MAX_BURST = 16 -> 16 grants to req0, then 1 grant to req1, then 16 to req0. oLocked deasserts at each handoff.
- Requester 2 sends x = 320, y = 10, then x = 5, y = 240, then x = 319, y = 239 -> all three granted. oWriteEn only for the third pixel (oX = 319, oY = 239), and oDropCount = 2.
- iHold = 1 for 3 cycles mid-burst of req1, with req0 and req1 requesting -> oGnt = 0 and oWriteEn = 0 during the hold. After the hold, req1 continues the burst with burst count unchanged.
- iReset asserted in cycle 5 of a req2 burst -> next cycle: oWriteEn = 0, oLocked = 0, oDropCount = 0. The first grant after reset goes to the lowest requesting index from pointer 0.
- Only req1 requests, with iLock = 0 -> grant every cycle, no bubbles, and oWriteEn stays high continuously.
